// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Upstream control stage for an 8-bit combinational ALU. One operation is
// accepted per in_valid/in_ready handshake. Its operands and select code are
// registered onto the ALU inputs. The ALU output enable (alu_latch) is then held
// for SETTLE_CYCLES cycles, and result and carry are captured into a holding
// register. That register is offered downstream on a res_valid/res_ready
// handshake. Illegal operations (select > 9, or divide with a zero divisor) are
// answered with an error result and never enable the ALU.
//
// Parameters
//   SETTLE_CYCLES  cycles alu_latch stays high before capture (1..15)
//   CNT_W          width of the ops_done / err_count counters
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operation request valid
//   in_ready   out  1      request can be accepted (IDLE only)
//   in_a       in   8      operand A
//   in_b       in   8      operand B
//   in_op      in   4      ALU select code, 0..9 legal
//   alu_a      out  8      registered operand A to ALU
//   alu_b      out  8      registered operand B to ALU
//   alu_sel    out  4      registered select to ALU
//   alu_latch  out  1      ALU output enable, high only in DRIVE
//   alu_out    in   8      ALU result bus
//   alu_carry  in   1      ALU carry flag
//   res_valid  out  1      result held and valid (HOLD)
//   res_ready  in   1      downstream accepts result
//   res_data   out  8      captured result, 0 on error
//   res_carry  out  1      captured carry, 0 on error
//   res_err    out  1      operation was rejected
//   ops_done   out  CNT_W  results consumed, wrapping
//   err_count  out  CNT_W  consumed results with res_err set, wrapping
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic [3:0]       in_op,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_sel,
   output logic             alu_latch,
   input  logic [7:0]       alu_out,
   input  logic             alu_carry,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic             res_carry,
   output logic             res_err,
   output logic [CNT_W-1:0] ops_done,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Counter reload value: the capture happens on the edge where the count is 0,
   // so loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles of alu_latch.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [3:0]       settle_cnt_r;
   logic             accept_s;
   logic             consume_s;
   logic             op_bad_s;

   logic             in_ready_nxt_s;
   logic             alu_latch_nxt_s;
   logic             res_valid_nxt_s;

   logic             in_ready_r;
   logic             alu_latch_r;
   logic             res_valid_r;
   logic [7:0]       alu_a_r;
   logic [7:0]       alu_b_r;
   logic [3:0]       alu_sel_r;
   logic [7:0]       res_data_r;
   logic             res_carry_r;
   logic             res_err_r;
   logic [CNT_W-1:0] ops_done_r;
   logic [CNT_W-1:0] err_count_r;

   // Screening rule: select codes above 9 do not exist, and select 3 (divide)
   // with a zero divisor is rejected before it ever reaches the ALU.
   function automatic logic op_is_illegal(input logic [3:0] op, input logic [7:0] b);
      return (op > 4'd9) || ((op == 4'd3) && (b == 8'd0));
   endfunction

   // Handshake qualifiers and request screening
   always_comb begin
      accept_s  = (state_r == ST_IDLE) && in_valid;
      consume_s = (state_r == ST_HOLD) && res_ready;
      op_bad_s  = op_is_illegal(in_op, in_b);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               if (op_bad_s) begin
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_DRIVE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (settle_cnt_r == 4'd0) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_DRIVE;
            end
         end
         ST_HOLD: begin
            if (res_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM output decode; decoded from the next state so the flops below hold
   // values that always agree with state_r
   always_comb begin
      in_ready_nxt_s  = 1'b0;
      alu_latch_nxt_s = 1'b0;
      res_valid_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_IDLE:  in_ready_nxt_s  = 1'b1;
         ST_DRIVE: alu_latch_nxt_s = 1'b1;
         ST_HOLD:  res_valid_nxt_s = 1'b1;
         default: begin
            in_ready_nxt_s  = 1'b0;
            alu_latch_nxt_s = 1'b0;
            res_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered handshake and ALU-enable outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_r  <= 1'b1;
         alu_latch_r <= 1'b0;
         res_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= in_ready_nxt_s;
         alu_latch_r <= alu_latch_nxt_s;
         res_valid_r <= res_valid_nxt_s;
      end
   end

   // Operand capture, settle timing and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a_r      <= 8'd0;
         alu_b_r      <= 8'd0;
         alu_sel_r    <= 4'd0;
         settle_cnt_r <= 4'd0;
         res_data_r   <= 8'd0;
         res_carry_r  <= 1'b0;
         res_err_r    <= 1'b0;
      end else if (accept_s) begin
         alu_a_r      <= in_a;
         alu_b_r      <= in_b;
         alu_sel_r    <= in_op;
         settle_cnt_r <= SETTLE_LOAD;
         if (op_bad_s) begin
            // Rejected op goes straight to HOLD with a zeroed error result.
            res_data_r  <= 8'd0;
            res_carry_r <= 1'b0;
            res_err_r   <= 1'b1;
         end else begin
            res_data_r  <= res_data_r;
            res_carry_r <= res_carry_r;
            res_err_r   <= res_err_r;
         end
      end else if (state_r == ST_DRIVE) begin
         if (settle_cnt_r == 4'd0) begin
            res_data_r  <= alu_out;
            res_carry_r <= alu_carry;
            res_err_r   <= 1'b0;
         end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
         end
      end else begin
         settle_cnt_r <= settle_cnt_r;
      end
   end

   // Consumption counters, free-running with wrap-around
   always_ff @(posedge clk) begin
      if (rst) begin
         ops_done_r  <= {CNT_W{1'b0}};
         err_count_r <= {CNT_W{1'b0}};
      end else if (consume_s) begin
         ops_done_r <= ops_done_r + CNT_ONE;
         if (res_err_r) begin
            err_count_r <= err_count_r + CNT_ONE;
         end else begin
            err_count_r <= err_count_r;
         end
      end else begin
         ops_done_r  <= ops_done_r;
         err_count_r <= err_count_r;
      end
   end

   assign in_ready  = in_ready_r;
   assign alu_latch = alu_latch_r;
   assign res_valid = res_valid_r;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_sel   = alu_sel_r;
   assign res_data  = res_data_r;
   assign res_carry = res_carry_r;
   assign res_err   = res_err_r;
   assign ops_done  = ops_done_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. Two instances share the clock:
//   unit 0: SETTLE_CYCLES=1, CNT_W=4  (arithmetic, errors, backpressure, wrap)
//   unit 1: SETTLE_CYCLES=4, CNT_W=16 (long settle, reset in the middle of DRIVE)
// A small behavioural ALU answers each instance's alu_a/alu_b/alu_sel.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic [1:0]  rst_v;
   logic [1:0]  in_valid_v;
   logic [1:0]  in_ready_v;
   logic [7:0]  in_a_v   [2];
   logic [7:0]  in_b_v   [2];
   logic [3:0]  in_op_v  [2];
   logic [7:0]  alu_a_v  [2];
   logic [7:0]  alu_b_v  [2];
   logic [3:0]  alu_sel_v[2];
   logic [1:0]  alu_latch_v;
   logic [7:0]  alu_out_v[2];
   logic [1:0]  alu_carry_v;
   logic [1:0]  res_valid_v;
   logic [1:0]  res_ready_v;
   logic [7:0]  res_data_v[2];
   logic [1:0]  res_carry_v;
   logic [1:0]  res_err_v;
   logic [3:0]  ops_done0;
   logic [3:0]  err_count0;
   logic [15:0] ops_done1;
   logic [15:0] err_count1;
   logic [8:0]  alu_res0;
   logic [8:0]  alu_res1;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ops[2];
   int exp_err[2];

   always #5 clk = ~clk;

   // Reference ALU: {carry, result}
   function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sel);
      case (sel)
         4'd0:    return {1'b0, a} + {1'b0, b};
         4'd1:    return {1'b0, a} - {1'b0, b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return (b != 8'd0) ? {1'b0, a / b} : 9'd0;
         4'd4:    return {1'b0, a | b};
         4'd5:    return {1'b0, a ^ b};
         4'd6:    return {1'b0, ~a};
         4'd7:    return {a, 1'b0};
         4'd8:    return {a[0], 1'b0, a[7:1]};
         4'd9:    return {1'b0, a} + 9'd1;
         default: return 9'd0;
      endcase
   endfunction

   assign alu_res0       = alu_model(alu_a_v[0], alu_b_v[0], alu_sel_v[0]);
   assign alu_res1       = alu_model(alu_a_v[1], alu_b_v[1], alu_sel_v[1]);
   assign alu_out_v[0]   = alu_latch_v[0] ? alu_res0[7:0] : 8'h00;
   assign alu_out_v[1]   = alu_latch_v[1] ? alu_res1[7:0] : 8'h00;
   assign alu_carry_v[0] = alu_latch_v[0] ? alu_res0[8]   : 1'b0;
   assign alu_carry_v[1] = alu_latch_v[1] ? alu_res1[8]   : 1'b0;

   alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut0 (
      .clk(clk), .rst(rst_v[0]),
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .in_a(in_a_v[0]), .in_b(in_b_v[0]), .in_op(in_op_v[0]),
      .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]), .alu_sel(alu_sel_v[0]),
      .alu_latch(alu_latch_v[0]), .alu_out(alu_out_v[0]), .alu_carry(alu_carry_v[0]),
      .res_valid(res_valid_v[0]), .res_ready(res_ready_v[0]),
      .res_data(res_data_v[0]), .res_carry(res_carry_v[0]), .res_err(res_err_v[0]),
      .ops_done(ops_done0), .err_count(err_count0)
   );

   alu_op_sequencer #(.SETTLE_CYCLES(4), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst_v[1]),
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .in_a(in_a_v[1]), .in_b(in_b_v[1]), .in_op(in_op_v[1]),
      .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]), .alu_sel(alu_sel_v[1]),
      .alu_latch(alu_latch_v[1]), .alu_out(alu_out_v[1]), .alu_carry(alu_carry_v[1]),
      .res_valid(res_valid_v[1]), .res_ready(res_ready_v[1]),
      .res_data(res_data_v[1]), .res_carry(res_carry_v[1]), .res_err(res_err_v[1]),
      .ops_done(ops_done1), .err_count(err_count1)
   );

   // Single comparison point for the whole bench
   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int get_ops(input int d);
      return (d == 0) ? int'(ops_done0) : int'(ops_done1);
   endfunction

   function automatic int get_errs(input int d);
      return (d == 0) ? int'(err_count0) : int'(err_count1);
   endfunction

   task automatic check_idle_reset(input int d, input string tag);
      check_eq({tag, ".in_ready"},  int'(in_ready_v[d]),  1);
      check_eq({tag, ".alu_latch"}, int'(alu_latch_v[d]), 0);
      check_eq({tag, ".res_valid"}, int'(res_valid_v[d]), 0);
      check_eq({tag, ".ops_done"},  get_ops(d),  0);
      check_eq({tag, ".err_count"}, get_errs(d), 0);
   endtask

   // One full transaction. Latency is counted in cycles from the accepting cycle
   // (the cycle in which in_valid meets in_ready) to the first cycle with
   // res_valid: SETTLE+1 for a legal op, 1 for a rejected one.
   task automatic do_op(input int d, input int settle,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic [7:0] exp_data, input logic exp_carry,
                        input logic exp_bad, input int hold_cycles);
      int lat;
      int latch_cycles;
      int guard;
      guard = 0;
      while (!in_ready_v[d] && guard < 50) begin
         step();
         guard++;
      end
      check_eq("pre.in_ready", int'(in_ready_v[d]), 1);
      in_valid_v[d] = 1'b1;
      in_a_v[d]     = a;
      in_b_v[d]     = b;
      in_op_v[d]    = op;
      step();
      in_valid_v[d] = 1'b0;
      check_eq("acc.alu_a",    int'(alu_a_v[d]),    int'(a));
      check_eq("acc.alu_b",    int'(alu_b_v[d]),    int'(b));
      check_eq("acc.alu_sel",  int'(alu_sel_v[d]),  int'(op));
      check_eq("acc.alu_latch", int'(alu_latch_v[d]), exp_bad ? 0 : 1);
      check_eq("acc.in_ready", int'(in_ready_v[d]), 0);
      lat = 1;
      latch_cycles = 0;
      while (!res_valid_v[d] && lat < 40) begin
         if (alu_latch_v[d]) latch_cycles++;
         step();
         lat++;
      end
      check_eq("latency",       lat,          exp_bad ? 1 : settle + 1);
      check_eq("latch_cycles",  latch_cycles, exp_bad ? 0 : settle);
      check_eq("hold.res_valid", int'(res_valid_v[d]), 1);
      check_eq("hold.alu_latch", int'(alu_latch_v[d]), 0);
      check_eq("hold.res_data",  int'(res_data_v[d]),  int'(exp_data));
      check_eq("hold.res_carry", int'(res_carry_v[d]), int'(exp_carry));
      check_eq("hold.res_err",   int'(res_err_v[d]),   int'(exp_bad));
      // Backpressure: a competing request must be ignored while held
      for (int i = 0; i < hold_cycles; i++) begin
         in_valid_v[d] = 1'b1;
         in_a_v[d]     = 8'hAA;
         step();
         check_eq("bp.res_valid", int'(res_valid_v[d]), 1);
         check_eq("bp.res_data",  int'(res_data_v[d]),  int'(exp_data));
         check_eq("bp.in_ready",  int'(in_ready_v[d]),  0);
         check_eq("bp.alu_a",     int'(alu_a_v[d]),     int'(a));
      end
      in_valid_v[d]  = 1'b0;
      res_ready_v[d] = 1'b1;
      step();
      res_ready_v[d] = 1'b0;
      exp_ops[d] = (exp_ops[d] + 1) % ((d == 0) ? 16 : 65536);
      if (exp_bad) exp_err[d] = (exp_err[d] + 1) % ((d == 0) ? 16 : 65536);
      check_eq("done.res_valid", int'(res_valid_v[d]), 0);
      check_eq("done.in_ready",  int'(in_ready_v[d]),  1);
      check_eq("done.ops_done",  get_ops(d),  exp_ops[d]);
      check_eq("done.err_count", get_errs(d), exp_err[d]);
   endtask

   initial begin
      rst_v       = 2'b11;
      in_valid_v  = 2'b00;
      res_ready_v = 2'b00;
      for (int i = 0; i < 2; i++) begin
         in_a_v[i]  = 8'd0;
         in_b_v[i]  = 8'd0;
         in_op_v[i] = 4'd0;
         exp_ops[i] = 0;
         exp_err[i] = 0;
      end
      step();
      step();
      rst_v = 2'b00;
      check_idle_reset(0, "rst0");
      check_eq("rst0.res_data", int'(res_data_v[0]), 0);
      check_eq("rst0.alu_a",    int'(alu_a_v[0]),    0);
      check_idle_reset(1, "rst1");

      // Unit 0, SETTLE_CYCLES=1
      do_op(0, 1, 8'd200, 8'd100, 4'd0,  8'h2C, 1'b1, 1'b0, 0); // 300 -> 0x12C
      do_op(0, 1, 8'd9,   8'd0,   4'd3,  8'h00, 1'b0, 1'b1, 0); // divide by zero
      do_op(0, 1, 8'd5,   8'd7,   4'hC,  8'h00, 1'b0, 1'b1, 0); // no such select
      do_op(0, 1, 8'd5,   8'd7,   4'd1,  8'hFE, 1'b1, 1'b0, 0); // 5-7 = 0x1FE
      do_op(0, 1, 8'h10,  8'h20,  4'd0,  8'h30, 1'b0, 1'b0, 10); // backpressure
      do_op(0, 1, 8'd100, 8'd7,   4'd3,  8'h0E, 1'b0, 1'b0, 0); // 100/7 = 14
      // Ten more adds bring the 4-bit ops_done from 6 around to 0
      for (int i = 0; i < 10; i++) begin
         do_op(0, 1, 8'(i), 8'd1, 4'd0, 8'(i + 1), 1'b0, 1'b0, 0);
      end
      check_eq("wrap.ops_done",  int'(ops_done0),  0);
      check_eq("wrap.err_count", int'(err_count0), 2);

      // Unit 1, SETTLE_CYCLES=4
      do_op(1, 4, 8'd3, 8'd4, 4'd0, 8'h07, 1'b0, 1'b0, 0);
      // Reset during the second DRIVE cycle abandons the operation
      in_valid_v[1] = 1'b1;
      in_a_v[1]     = 8'd50;
      in_b_v[1]     = 8'd60;
      in_op_v[1]    = 4'd0;
      step();
      in_valid_v[1] = 1'b0;
      check_eq("mid.alu_latch", int'(alu_latch_v[1]), 1);
      step();
      check_eq("mid.alu_latch2", int'(alu_latch_v[1]), 1);
      rst_v[1] = 1'b1;
      step();
      rst_v[1] = 1'b0;
      check_idle_reset(1, "midrst");
      exp_ops[1] = 0;
      exp_err[1] = 0;
      step();
      check_eq("midrst.res_valid_after", int'(res_valid_v[1]), 0);
      do_op(1, 4, 8'd1, 8'd1, 4'd0, 8'h02, 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
